// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: start/done handshake and operand/product bus for the shift-add multiplier
interface shift_add_mult_ctrl_if #(parameter int WIDTH = 4);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned WIDTH x WIDTH shift-and-add multiplier with start/done handshake
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   m_q, a_q, q_q, add_b, sum, a_d, q_d;
  logic [WIDTH:0]     cy;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, fin;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // one ripple-carry adder reused every iteration; carry-out lands in the shifted-in MSB of A
  assign add_b = q_q[0] ? m_q : '0;
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = a_q[i] ^ add_b[i] ^ cy[i];
    assign cy[i+1] = (a_q[i] & add_b[i]) | (cy[i] & (a_q[i] ^ add_b[i]));
  end
  assign a_d = {cy[WIDTH], sum[WIDTH-1:1]};
  assign q_d = {sum[0], q_q[WIDTH-1:1]};
`ifdef EARLY_TERM_EN
  logic [CW-1:0]    rem;
  logic [WIDTH-1:0] rem_mask;
  // low rem bits of Q are still unprocessed multiplier bits; when zero the rest is pure shifting
  assign rem      = CW'(WIDTH - 1) - cnt_q;
  assign rem_mask = ~({WIDTH{1'b1}} << rem);
  assign fin      = ~|(q_d & rem_mask);
  assign prod_d   = {a_d, q_d} >> rem;
`else
  assign fin    = (cnt_q == CW'(WIDTH - 1));
  assign prod_d = {a_d, q_d};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          busy_q  <= bus.start;
          state_q <= bus.start ? BUSY : IDLE;
          if (bus.start) begin
            m_q   <= bus.a;
            q_q   <= bus.b;
            a_q   <= '0;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (fin) begin
            prod_q  <= prod_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed self-checking bench for shift_add_mult_ctrl (WIDTH=4)
module tb_shift_add_mult_ctrl;
  localparam int W = 4;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  shift_add_mult_ctrl_if #(.WIDTH(W)) bif ();
  shift_add_mult_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [2*W-1:0] p, output logic busy_acc);
    @(posedge clk); #1;
    bif.start = 1'b1; bif.a = av; bif.b = bv;
    @(posedge clk); #1;
    bif.start = 1'b0; bif.a = ~av; bif.b = ~bv;
    busy_acc = bif.busy;
    lat = 0;
    while (bif.done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bif.product;
  endtask

  task automatic test_reset;
    bif.start = 1'b0; bif.a = '0; bif.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bif.busy), 0);
    chk("reset_done", 32'(bif.done), 0);
    chk("reset_product", 32'(bif.product), 0);
    rst_n = 1'b1;
  endtask

  task automatic test_max;
    int lat; logic [2*W-1:0] p; logic ba;
    run_op(4'd15, 4'd15, lat, p, ba);
    chk("max_busy_at_accept", 32'(ba), 1);
    chk("max_latency", 32'(lat), ET ? 4 : 4);
    chk("max_product", 32'(p), 225);
    chk("max_busy_in_done", 32'(bif.busy), 1);
    @(posedge clk); #1;
    chk("max_done_one_cycle", 32'(bif.done), 0);
    chk("max_busy_after_done", 32'(bif.busy), 0);
  endtask

  task automatic test_hold;
    int lat; logic [2*W-1:0] p; logic ba;
    run_op(4'd13, 4'd11, lat, p, ba);
    chk("hold_product", 32'(p), 143);
    chk("hold_latency", 32'(lat), 4);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_product_idle", 32'(bif.product), 143);
    chk("hold_done_idle", 32'(bif.done), 0);
  endtask

  task automatic test_back_to_back;
    int n;
    int dones;
    @(posedge clk); #1;
    bif.start = 1'b1; bif.a = 4'd2; bif.b = 4'd3;
    @(posedge clk); #1;
    bif.a = 4'd15; bif.b = 4'd15;
    n = 0;
    while (bif.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_first_latency", 32'(n), ET ? 2 : 4);
    chk("b2b_first_product", 32'(bif.product), 6);
    bif.a = 4'd2; bif.b = 4'd3;
    @(posedge clk); #1;
    chk("b2b_reaccept_busy", 32'(bif.busy), 1);
    chk("b2b_reaccept_done", 32'(bif.done), 0);
    dones = 0;
    n = 0;
    while (bif.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bif.done === 1'b1) dones++;
    end
    chk("b2b_second_latency", 32'(n), ET ? 2 : 4);
    chk("b2b_second_product", 32'(bif.product), 6);
    chk("b2b_single_done", 32'(dones), 1);
    bif.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_idle_after_release", 32'(bif.busy), 0);
  endtask

  task automatic test_zero;
    int lat; logic [2*W-1:0] p; logic ba;
    run_op(4'd9, 4'd0, lat, p, ba);
    chk("zero_b_product", 32'(p), 0);
    chk("zero_b_latency", 32'(lat), ET ? 1 : 4);
    run_op(4'd0, 4'd9, lat, p, ba);
    chk("zero_a_product", 32'(p), 0);
    chk("zero_a_latency", 32'(lat), 4);
  endtask

  task automatic test_reset_mid;
    int lat; logic [2*W-1:0] p; logic ba;
    int seen;
    run_op(4'd3, 4'd3, lat, p, ba);
    chk("mid_pre_product", 32'(p), 9);
    @(posedge clk); #1;
    bif.start = 1'b1; bif.a = 4'd15; bif.b = 4'd15;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bif.busy), 0);
    chk("mid_done", 32'(bif.done), 0);
    chk("mid_product", 32'(bif.product), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bif.done === 1'b1 || bif.busy === 1'b1) seen++;
    end
    chk("mid_no_done_after_reset", 32'(seen), 0);
    run_op(4'd5, 4'd5, lat, p, ba);
    chk("mid_next_product", 32'(p), 25);
    chk("mid_next_latency", 32'(lat), ET ? 3 : 4);
  endtask

  task automatic test_early;
    int lat; logic [2*W-1:0] p; logic ba;
    run_op(4'd7, 4'd1, lat, p, ba);
    chk("et_7x1_product", 32'(p), 7);
    chk("et_7x1_latency", 32'(lat), ET ? 1 : 4);
    run_op(4'd7, 4'd2, lat, p, ba);
    chk("et_7x2_product", 32'(p), 14);
    chk("et_7x2_latency", 32'(lat), ET ? 2 : 4);
    run_op(4'd15, 4'd8, lat, p, ba);
    chk("et_15x8_product", 32'(p), 120);
    chk("et_15x8_latency", 32'(lat), 4);
    run_op(4'd3, 4'd0, lat, p, ba);
    chk("et_3x0_product", 32'(p), 0);
    chk("et_3x0_latency", 32'(lat), ET ? 1 : 4);
  endtask

  initial begin
    test_reset;
    test_max;
    test_hold;
    test_back_to_back;
    test_zero;
    test_reset_mid;
    test_early;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
